// File: rtl/ecdsa_pkg.sv
// Shared types and constants for the ECDSA verify-job front end.
package ecdsa_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } state_e;

  localparam logic [7:0] ECDSA_JOB_MAGIC = 8'hEC;
  localparam logic [7:0] OP_VERIFY       = 8'h01;

  localparam int unsigned ERR_CNT_W = 16;

  // Increment that sticks at all-ones.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ecdsa_job_unpacker.sv
// Assembles header + payload beats from the CDC FIFO into one wide ECDSA verify job,
// rejecting headers with a bad magic byte and holding the FIFO off while a job is pending.
module ecdsa_job_unpacker
  import ecdsa_pkg::*;
#(
  parameter int unsigned WIDTH      = 128,
  parameter int unsigned FIELD_W    = 256,
  parameter int unsigned NUM_FIELDS = 5,
  parameter logic [7:0]  MAGIC      = ECDSA_JOB_MAGIC
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH-1:0]              in_tdata,
  input  logic                          in_tvalid,
  output logic                          in_tready,
  output logic [NUM_FIELDS*FIELD_W-1:0] job_tdata,
  output logic [7:0]                    job_opcode,
  output logic                          job_tvalid,
  input  logic                          job_tready,
  output logic [ERR_CNT_W-1:0]          err_cnt
);

  localparam int unsigned BPF           = FIELD_W / WIDTH;
  localparam int unsigned PAYLOAD_BEATS = NUM_FIELDS * BPF;
  localparam int unsigned CNT_W         = (PAYLOAD_BEATS > 1) ? $clog2(PAYLOAD_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PAYLOAD_BEATS - 1);

  state_e                 state_q;
  logic [CNT_W-1:0]       beat_cnt_q;
  logic [WIDTH-1:0]       slot_q [PAYLOAD_BEATS];
  logic [7:0]             opcode_q;
  logic                   job_tvalid_q;
  logic                   in_tready_q;
  logic [ERR_CNT_W-1:0]   err_cnt_q;
  logic                   beat_acc;

  assign beat_acc = in_tvalid & in_tready_q;

  // Header check, payload capture into beat-indexed slots, and job hand-off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      opcode_q     <= '0;
      job_tvalid_q <= 1'b0;
      in_tready_q  <= 1'b0;
      err_cnt_q    <= '0;
      for (int i = 0; i < int'(PAYLOAD_BEATS); i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          in_tready_q <= 1'b1;
          if (beat_acc) begin
            if (in_tdata[WIDTH-1 -: 8] == MAGIC) begin
              opcode_q   <= in_tdata[7:0];
              beat_cnt_q <= '0;
              state_q    <= COLLECT;
            end else begin
              err_cnt_q <= sat_inc(err_cnt_q);
            end
          end
        end
        COLLECT: begin
          in_tready_q <= 1'b1;
          if (beat_acc) begin
            slot_q[beat_cnt_q] <= in_tdata;
            if (beat_cnt_q == LAST_BEAT) begin
              state_q      <= PRESENT;
              job_tvalid_q <= 1'b1;
              in_tready_q  <= 1'b0;
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
          end
        end
        PRESENT: begin
          in_tready_q <= 1'b0;
          if (job_tready) begin
            job_tvalid_q <= 1'b0;
            in_tready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q      <= IDLE;
          job_tvalid_q <= 1'b0;
          in_tready_q  <= 1'b0;
        end
      endcase
    end
  end

  // Slot k carries beat k, so each field is low beat first.
  for (genvar k = 0; k < int'(PAYLOAD_BEATS); k++) begin : g_pack
    assign job_tdata[k*WIDTH +: WIDTH] = slot_q[k];
  end

  assign in_tready  = in_tready_q;
  assign job_opcode = opcode_q;
  assign job_tvalid = job_tvalid_q;
  assign err_cnt    = err_cnt_q;

endmodule
